// File: rtl/vga_timing_gen_pkg.sv
// Shared types and defaults for the VGA timing generator:
// axis phase enum, per-axis timing bundle, control-output bundle,
// default 640x480@60 timing and small timing helpers.
package vga_pkg;

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      FRONT  = 2'd1,
      SYNC   = 2'd2,
      BACK   = 2'd3
   } phase_t;

   typedef struct packed {
      int active;
      int fp;
      int sync;
      int bp;
   } timing_t;

   // Control outputs that travel together (and through the lead delay line).
   typedef struct packed {
      logic hs;
      logic vs;
      logic sync_b;
      logic blank_b;
      logic line;
      logic frame;
   } ctrl_t;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam timing_t DEF_H_TIMING = '{active: DEF_H_ACTIVE, fp: DEF_H_FP,
                                        sync: DEF_H_SYNC, bp: DEF_H_BP};
   localparam timing_t DEF_V_TIMING = '{active: DEF_V_ACTIVE, fp: DEF_V_FP,
                                        sync: DEF_V_SYNC, bp: DEF_V_BP};

   // Positions per axis period.
   function automatic int total_of(input timing_t t);
      return t.active + t.fp + t.sync + t.bp;
   endfunction

   // Phase a position falls in; empty porches simply never match.
   function automatic phase_t phase_of(input int pos, input timing_t t);
      phase_t ph;
      if (pos < t.active) begin
         ph = ACTIVE;
      end else if (pos < t.active + t.fp) begin
         ph = FRONT;
      end else if (pos < t.active + t.fp + t.sync) begin
         ph = SYNC;
      end else begin
         ph = BACK;
      end
      return ph;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Output bundle of the VGA timing generator towards pixelStore and the DAC.
interface vga_timing_gen_if #(
   parameter int CW = 10
) ();
   logic          pix_tick;
   logic          hsync;
   logic          vsync;
   logic          sync_b;
   logic          blank_b;
   logic          line_start;
   logic          frame_start;
   logic [CW-1:0] vgaX;
   logic [CW-1:0] vgaY;

   modport master (
      output pix_tick, hsync, vsync, sync_b, blank_b,
             line_start, frame_start, vgaX, vgaY
   );

   modport slave (
      input  pix_tick, hsync, vsync, sync_b, blank_b,
             line_start, frame_start, vgaX, vgaY
   );
endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// One timing axis (horizontal or vertical): position counter that wraps at
// the axis total, a registered phase state tracking the counter, the wrap
// strobe that carries into the next axis, and the axis sync level.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter timing_t TIM = DEF_H_TIMING,
   parameter bit      POL = 1'b0,
   parameter int      CW  = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          adv,
   output logic [CW-1:0] count,
   output logic          wrap,
   output phase_t        phase,
   output logic          sync_lvl
);

   localparam int            TOTAL = total_of(TIM);
   localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);
   localparam logic [CW-1:0] ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0] ONE   = CW'(1);

   // Empty active or sync regions cannot form a valid raster.
   generate
      if (TIM.active <= 0 || TIM.sync <= 0 || TIM.fp < 0 || TIM.bp < 0) begin : g_bad_len
         $error("vga_axis_counter: active and sync must be non-empty, porches non-negative");
      end
      if ((TOTAL - 1) >= (1 << CW)) begin : g_bad_cw
         $error("vga_axis_counter: CW too narrow for the axis total");
      end
   endgenerate

   logic [CW-1:0] count_r;
   logic [CW-1:0] count_nxt_s;
   phase_t        phase_r;

   assign count_nxt_s = (count_r == LAST) ? ZERO : (count_r + ONE);

   // Position counter and phase state both step on the advance strobe.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_r <= ZERO;
         phase_r <= ACTIVE;
      end else if (adv) begin
         count_r <= count_nxt_s;
         phase_r <= phase_of(32'(count_nxt_s), TIM);
      end
   end

   assign count    = count_r;
   assign phase    = phase_r;
   assign wrap     = adv & (count_r == LAST);
   assign sync_lvl = (phase_r == SYNC) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-rate divider, H/V axis counters,
// registered sync/blank/marker outputs and pixel coordinates.
// Optional macro VGA_COORD_LEAD_EN: coordinates run LEAD pixel strobes ahead
// of the control outputs, which pass through a LEAD-deep delay line.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE  = DEF_H_ACTIVE,
   parameter int H_FP      = DEF_H_FP,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BP      = DEF_H_BP,
   parameter int V_ACTIVE  = DEF_V_ACTIVE,
   parameter int V_FP      = DEF_V_FP,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BP      = DEF_V_BP,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int CLK_DIV   = 1,
   parameter int CW        = 10,
   parameter int LEAD      = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   vga_timing_gen_if.master  vga
);

   localparam timing_t       H_TIM    = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
   localparam timing_t       V_TIM    = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
   localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] ZERO     = {CW{1'b0}};
   localparam ctrl_t         CTRL_RST = '{hs: ~HSYNC_POL, vs: ~VSYNC_POL, sync_b: 1'b1,
                                          blank_b: 1'b0, line: 1'b0, frame: 1'b0};

   generate
      if (CLK_DIV < 1) begin : g_bad_div
         $error("vga_timing_gen: CLK_DIV must be at least 1");
      end
   endgenerate

   logic [DW-1:0] div_r;
   logic          tick_s;
   logic [CW-1:0] h_count_s;
   logic [CW-1:0] v_count_s;
   logic          h_wrap_s;
   logic          unused_v_wrap_s;
   phase_t        h_phase_s;
   phase_t        v_phase_s;
   logic          h_sync_lvl_s;
   logic          v_sync_lvl_s;
   ctrl_t         ctrl_now_s;
   ctrl_t         ctrl_out_s;

   logic          pix_tick_r;
   logic          hsync_r;
   logic          vsync_r;
   logic          sync_b_r;
   logic          blank_b_r;
   logic          line_start_r;
   logic          frame_start_r;
   logic [CW-1:0] vga_x_r;
   logic [CW-1:0] vga_y_r;

   assign tick_s = en & (div_r == DIV_LAST);

   // Pixel-rate divider: counts clk cycles per pixel, frozen while disabled.
   always_ff @(posedge clk) begin
      if (!reset) begin
         div_r <= {DW{1'b0}};
      end else if (en) begin
         div_r <= tick_s ? {DW{1'b0}} : (div_r + DW'(1));
      end
   end

   vga_axis_counter #(.TIM(H_TIM), .POL(HSYNC_POL), .CW(CW)) u_h (
      .clk      (clk),
      .reset    (reset),
      .adv      (tick_s),
      .count    (h_count_s),
      .wrap     (h_wrap_s),
      .phase    (h_phase_s),
      .sync_lvl (h_sync_lvl_s)
   );

   vga_axis_counter #(.TIM(V_TIM), .POL(VSYNC_POL), .CW(CW)) u_v (
      .clk      (clk),
      .reset    (reset),
      .adv      (h_wrap_s),
      .count    (v_count_s),
      .wrap     (unused_v_wrap_s),
      .phase    (v_phase_s),
      .sync_lvl (v_sync_lvl_s)
   );

   // Control values belonging to the pixel the counters point at right now.
   always_comb begin
      ctrl_now_s         = CTRL_RST;
      ctrl_now_s.hs      = h_sync_lvl_s;
      ctrl_now_s.vs      = v_sync_lvl_s;
      ctrl_now_s.sync_b  = ~((h_phase_s == SYNC) | (v_phase_s == SYNC));
      ctrl_now_s.blank_b = (h_phase_s == ACTIVE) & (v_phase_s == ACTIVE);
      ctrl_now_s.line    = (h_count_s == ZERO);
      ctrl_now_s.frame   = (h_count_s == ZERO) & (v_count_s == ZERO);
   end

`ifdef VGA_COORD_LEAD_EN
   generate
      if (LEAD < 1) begin : g_bad_lead
         $error("vga_timing_gen: LEAD must be at least 1 with the coordinate lead enabled");
      end
   endgenerate

   ctrl_t pipe_r [LEAD];

   // Delay line holding the last LEAD pixels' control values, stepped per pixel.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < LEAD; i++) begin
            pipe_r[i] <= CTRL_RST;
         end
      end else if (tick_s) begin
         pipe_r[0] <= ctrl_now_s;
         for (int i = 1; i < LEAD; i++) begin
            pipe_r[i] <= pipe_r[i-1];
         end
      end
   end

   assign ctrl_out_s = pipe_r[LEAD-1];
`else
   assign ctrl_out_s = ctrl_now_s;
`endif

   // Output registers: load on the pixel strobe, stop cleanly when disabled.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pix_tick_r    <= 1'b0;
         hsync_r       <= ~HSYNC_POL;
         vsync_r       <= ~VSYNC_POL;
         sync_b_r      <= 1'b1;
         blank_b_r     <= 1'b0;
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
         vga_x_r       <= ZERO;
         vga_y_r       <= ZERO;
      end else if (!en) begin
         pix_tick_r    <= 1'b0;
         blank_b_r     <= 1'b0;
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
      end else if (tick_s) begin
         pix_tick_r    <= 1'b1;
         hsync_r       <= ctrl_out_s.hs;
         vsync_r       <= ctrl_out_s.vs;
         sync_b_r      <= ctrl_out_s.sync_b;
         blank_b_r     <= ctrl_out_s.blank_b;
         line_start_r  <= ctrl_out_s.line;
         frame_start_r <= ctrl_out_s.frame;
         vga_x_r       <= h_count_s;
         vga_y_r       <= v_count_s;
      end else begin
         pix_tick_r    <= 1'b0;
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
      end
   end

   assign vga.pix_tick    = pix_tick_r;
   assign vga.hsync       = hsync_r;
   assign vga.vsync       = vsync_r;
   assign vga.sync_b      = sync_b_r;
   assign vga.blank_b     = blank_b_r;
   assign vga.line_start  = line_start_r;
   assign vga.frame_start = frame_start_r;
   assign vga.vgaX        = vga_x_r;
   assign vga.vgaY        = vga_y_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a small 14x8 raster: three
// instances (CLK_DIV=1 active-low, CLK_DIV=4 active-low, CLK_DIV=1
// active-high) checked every clk against a pixel-index reference model
// through a scoreboard, plus directed frame-window and control checks.
module tb_vga_timing_gen;

   localparam int HT = 14;
   localparam int FT = 112;
   localparam int HA = 8;
   localparam int VA = 4;
   localparam int HS0 = 10;
   localparam int HS1 = 13;
   localparam int VS0 = 5;
   localparam int VS1 = 7;
`ifdef VGA_COORD_LEAD_EN
   localparam int LEADT = 2;
`else
   localparam int LEADT = 0;
`endif
   localparam int DIVS [3] = '{1, 4, 1};
   localparam bit POLS [3] = '{1'b0, 1'b0, 1'b1};

   typedef struct packed {
      logic       pix;
      logic       hs;
      logic       vs;
      logic       sb;
      logic       bl;
      logic       ls;
      logic       fs;
      logic [3:0] x;
      logic [3:0] y;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic en = 1'b0;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit meas = 1'b0;

   vga_timing_gen_if #(.CW(4)) if0 ();
   vga_timing_gen_if #(.CW(4)) if1 ();
   vga_timing_gen_if #(.CW(4)) if2 ();

   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(1), .CW(4), .LEAD(2))
      u0 (.clk(clk), .reset(reset), .en(en), .vga(if0));

   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(4), .CW(4), .LEAD(2))
      u1 (.clk(clk), .reset(reset), .en(en), .vga(if1));

   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(1), .CW(4), .LEAD(2))
      u2 (.clk(clk), .reset(reset), .en(en), .vga(if2));

   always #5 clk = ~clk;

   exp_t obs [3];
   assign obs[0] = {if0.pix_tick, if0.hsync, if0.vsync, if0.sync_b, if0.blank_b,
                    if0.line_start, if0.frame_start, if0.vgaX, if0.vgaY};
   assign obs[1] = {if1.pix_tick, if1.hsync, if1.vsync, if1.sync_b, if1.blank_b,
                    if1.line_start, if1.frame_start, if1.vgaX, if1.vgaY};
   assign obs[2] = {if2.pix_tick, if2.hsync, if2.vsync, if2.sync_b, if2.blank_b,
                    if2.line_start, if2.frame_start, if2.vgaX, if2.vgaY};

   // reference model state, one slot per instance
   int   m_div [3];
   int   m_pos [3];
   int   m_nt  [3];
   exp_t mexp  [3];
   exp_t sbq   [3][$];

   // window counters for the directed frame checks
   int w0_bl = 0, w0_hsl = 0, w0_vsl = 0, w0_fs = 0;
   int w1_tick = 0, w1_hsl = 0, w1_fs = 0;
   int w2_hsh = 0, w2_sbl = 0;

   // {hs, vs, sync_b, blank_b, line, frame} for raster pixel index dpos
   function automatic logic [5:0] ref_ctrl(input int dpos, input bit pol);
      int h;
      int v;
      bit ha;
      bit va;
      h  = dpos % HT;
      v  = dpos / HT;
      ha = (h >= HS0) && (h < HS1);
      va = (v >= VS0) && (v < VS1);
      return {ha ? pol : ~pol, va ? pol : ~pol, ~(ha | va),
              (h < HA) && (v < VA), h == 0, dpos == 0};
   endfunction

   task automatic model(input int i, input logic r, input logic e);
      logic [5:0] c;
      if (!r) begin
         m_div[i] = 0;
         m_pos[i] = 0;
         m_nt[i]  = 0;
         mexp[i]  = '{pix: 1'b0, hs: ~POLS[i], vs: ~POLS[i], sb: 1'b1, bl: 1'b0,
                      ls: 1'b0, fs: 1'b0, x: 4'd0, y: 4'd0};
      end else if (!e) begin
         mexp[i].pix = 1'b0;
         mexp[i].bl  = 1'b0;
         mexp[i].ls  = 1'b0;
         mexp[i].fs  = 1'b0;
      end else if (m_div[i] == DIVS[i] - 1) begin
         m_div[i] = 0;
         if (m_nt[i] >= LEADT)
            c = ref_ctrl((m_pos[i] - LEADT + FT) % FT, POLS[i]);
         else
            c = {~POLS[i], ~POLS[i], 1'b1, 1'b0, 1'b0, 1'b0};
         mexp[i] = '{pix: 1'b1, hs: c[5], vs: c[4], sb: c[3], bl: c[2], ls: c[1], fs: c[0],
                     x: 4'(m_pos[i] % HT), y: 4'(m_pos[i] / HT)};
         m_pos[i] = (m_pos[i] + 1) % FT;
         m_nt[i]  = m_nt[i] + 1;
      end else begin
         m_div[i]    = m_div[i] + 1;
         mexp[i].pix = 1'b0;
         mexp[i].ls  = 1'b0;
         mexp[i].fs  = 1'b0;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   // one clk: drive inputs, push the expectation, then compare after the edge
   task automatic step(input logic r, input logic e);
      exp_t ex;
      @(negedge clk);
      reset = r;
      en    = e;
      for (int i = 0; i < 3; i++) begin
         model(i, r, e);
         sbq[i].push_back(mexp[i]);
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 3; i++) begin
         ex = sbq[i].pop_front();
         checks++;
         assert (obs[i] === ex) else begin
            errors++;
            $error("FAIL sb_u%0d cyc=%0d got=%h want=%h", i, cyc, obs[i], ex);
         end
      end
      if (meas && cyc >= 1 + LEADT && cyc <= FT + LEADT) begin
         w0_bl  += int'(obs[0].bl);
         w0_hsl += int'(!obs[0].hs);
         w0_vsl += int'(!obs[0].vs);
         w0_fs  += int'(obs[0].fs);
         w2_hsh += int'(obs[2].hs);
         w2_sbl += int'(!obs[2].sb);
      end
      if (meas && cyc >= 4 + 4 * LEADT && cyc <= 4 * FT + 3 + 4 * LEADT) begin
         w1_tick += int'(obs[1].pix);
         w1_hsl  += int'(!obs[1].hs);
         w1_fs   += int'(obs[1].fs);
      end
   endtask

   initial begin
      bit found;
      int hold_ticks;

      // reset state
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
      check("rst_u0_hsync", 32'(if0.hsync), 32'd1);
      check("rst_u2_hsync", 32'(if2.hsync), 32'd0);
      check("rst_u2_vsync", 32'(if2.vsync), 32'd0);
      check("rst_u2_sync_b", 32'(if2.sync_b), 32'd1);

      // one full frame from release on every instance
      cyc  = 0;
      meas = 1'b1;
      for (int k = 0; k < 470; k++) step(1'b1, 1'b1);
      meas = 1'b0;
      check("u0_blank_per_frame", 32'(w0_bl), 32'd32);
      check("u0_hsync_low_clks", 32'(w0_hsl), 32'd24);
      check("u0_vsync_low_clks", 32'(w0_vsl), 32'd28);
      check("u0_frame_starts", 32'(w0_fs), 32'd1);
      check("u1_pix_ticks", 32'(w1_tick), 32'd112);
      check("u1_hsync_low_clks", 32'(w1_hsl), 32'd96);
      check("u1_frame_starts", 32'(w1_fs), 32'd1);
      check("u2_hsync_high_clks", 32'(w2_hsh), 32'd24);
      check("u2_sync_b_low_clks", 32'(w2_sbl), 32'd46);

      // drop en while u0 shows pixel (5,2)
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         step(1'b1, 1'b1);
         if (mexp[0].pix && mexp[0].x == 4'd5 && mexp[0].y == 4'd2) found = 1'b1;
      end
      check("find_x5_y2", 32'(found), 32'd1);
      hold_ticks = 0;
      for (int k = 0; k < 20; k++) begin
         step(1'b1, 1'b0);
         hold_ticks += int'(obs[0].pix) + int'(obs[1].pix);
      end
      check("hold_no_ticks", 32'(hold_ticks), 32'd0);
      check("hold_vgaX", 32'(if0.vgaX), 32'd5);
      check("hold_vgaY", 32'(if0.vgaY), 32'd2);
      check("hold_blank_b", 32'(if0.blank_b), 32'd0);
      step(1'b1, 1'b1);
      check("resume_vgaX", 32'(if0.vgaX), 32'd6);
      check("resume_pix_tick", 32'(if0.pix_tick), 32'd1);

      // reset pulsed mid-frame at vcnt=6
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         step(1'b1, 1'b1);
         if (mexp[0].pix && mexp[0].y == 4'd6) found = 1'b1;
      end
      check("find_y6", 32'(found), 32'd1);
      step(1'b0, 1'b1);
      check("midrst_vgaX", 32'(if0.vgaX), 32'd0);
      check("midrst_vgaY", 32'(if0.vgaY), 32'd0);
      check("midrst_hsync", 32'(if0.hsync), 32'd1);
      check("midrst_pix_tick", 32'(if0.pix_tick), 32'd0);
      check("midrst_u2_sync_b", 32'(if2.sync_b), 32'd1);
      step(1'b0, 1'b1);
      cyc = 0;
      for (int k = 0; k < LEADT + 1; k++) step(1'b1, 1'b1);
      check("first_frame_start", 32'(if0.frame_start), 32'd1);
      check("first_line_start", 32'(if0.line_start), 32'd1);

      // free run to cover further frames and the CLK_DIV=4 instance
      for (int k = 0; k < 300; k++) step(1'b1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator and the next generation of the current vgaController.
- Produces hsync/vsync, blanking, composite sync, pixel strobe, frame/line markers and pixel coordinates for pixelStore and the DAC path.
- Any resolution, porch set and sync polarity, plus an integer clock divider for the pixel rate.
- Sits between the top-level clock and the pixel-fetch logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync
- CLK_DIV, 1, clk cycles per pixel (>=1)
- CW, 10, coordinate counter width; must hold H_TOTAL-1 and V_TOTAL-1
- LEAD, 2, coordinate lead in pixels (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- en  in  1  run enable; low freezes timing
- pix_tick  out  1  one-clk strobe marking each pixel period
- hsync  out  1  horizontal sync, polarity HSYNC_POL
- vsync  out  1  vertical sync, polarity VSYNC_POL
- sync_b  out  1  active-low composite sync, for the DAC
- blank_b  out  1  high only inside the active area
- line_start  out  1  pulse on the pix_tick at hcnt=0
- frame_start  out  1  pulse on the pix_tick at hcnt=0, vcnt=0
- vgaX  out  CW  horizontal count
- vgaY  out  CW  vertical count

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Reset (reset==0 at a clk edge) applies to every register:
  - div counter = 0, hcnt = 0, vcnt = 0, pix_tick = 0, line_start = 0, frame_start = 0, blank_b = 0.
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL, sync_b = 1, vgaX = 0, vgaY = 0.
- Divider: counts 0..CLK_DIV-1 while en=1. pix_tick is asserted on the clk after the divider reaches CLK_DIV-1. With CLK_DIV=1, pix_tick is high every cycle.
- Counters advance only on pix_tick:
  - hcnt wraps H_TOTAL-1 -> 0.
  - On that wrap, vcnt increments; vcnt wraps V_TOTAL-1 -> 0 in the same tick.
- Horizontal phase FSM, decoded from hcnt: ACTIVE [0, H_ACTIVE) -> FRONT -> SYNC [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) -> BACK -> ACTIVE.
- Vertical phase FSM: same scheme on vcnt.
- All outputs are registered. They reflect the (hcnt, vcnt) of the current pixel and update in the same clk as pix_tick, with one-cycle latency from counter state.
  - hsync = HSYNC_POL in H SYNC phase, else its inverse; vsync likewise.
  - blank_b = H ACTIVE & V ACTIVE.
  - sync_b = ~(hsync asserted | vsync asserted).
- vgaX/vgaY equal hcnt/vcnt, including the porch and sync regions; consumers gate with blank_b.
- line_start and frame_start are one clk wide and coincide with pix_tick.
- en=0:
  - divider, hcnt and vcnt hold; pix_tick, line_start and frame_start = 0.
  - blank_b = 0; sync levels hold their last value.
  - Resuming en=1 continues from the held position.
- Reset mid-frame: back to hcnt=vcnt=0 on the next edge. The first frame_start after release is on the first pix_tick.
- Zero-length porches (H_FP=0 etc.) are legal: phases are skipped.
- Zero-length sync or active regions are illegal; guarded by an elaboration-time assertion.

Optional Feature:
- Macro: VGA_COORD_LEAD_EN.
- Defined:
  - vgaX/vgaY run LEAD pix_ticks ahead of hsync/vsync/blank_b/sync_b/line_start/frame_start. This covers pixelStore read latency.
  - Implemented by delaying the control outputs through a LEAD-deep shift register, advanced on pix_tick. Registers reset to the reset values above.
  - Coordinates wrap normally.
- Undefined: no delay line; all outputs are aligned as described in Behaviour. LEAD is ignored.

Decomposition:
- Package vga_pkg holds:
  - the phase typedef enum {ACTIVE, FRONT, SYNC, BACK};
  - default 640x480@60 timing localparams;
  - a timing_t struct bundling active/fp/sync/bp.
- Natural sub-module: vga_axis_counter, instantiated twice (H and V). It takes count/advance inputs and outputs a wrap strobe, the phase, and the sync level.

Test Plan:
- Small timing (H 8/2/3/1 = 14, V 4/1/2/1 = 8, CLK_DIV=1, active-low sync) -> hsync low for hcnt 10..12 every 14 clks; vsync low for vcnt 5..6 (28 clks); frame_start every 112 clks; blank_b high for exactly 32 clks per frame.
- CLK_DIV=4 with the same timing -> pix_tick every 4th clk; hsync low for exactly 12 clks; frame period 448 clks.
- HSYNC_POL=1, VSYNC_POL=1 -> sync outputs high when asserted; sync_b low whenever either is asserted; reset drives hsync=vsync=0 and sync_b=1.
- en dropped at hcnt=5, vcnt=2 for 20 clks -> vgaX=5 and vgaY=2 held, blank_b=0, no pix_tick; the count resumes at 6.
- Reset pulsed mid-frame (vcnt=6) -> all outputs at reset values on the next edge; first frame_start on the first pix_tick after release.
- With VGA_COORD_LEAD_EN and LEAD=2 -> vgaX reads 2 when blank_b first rises in a line; blank_b falls when vgaX=H_ACTIVE+2.
